// File: rtl/ship_sprite_engine.sv
// Ship sprite renderer: on a new heading command, erases the previously drawn
// sprite and redraws it pixel by pixel through a VGA pixel-write port.
module ship_sprite_engine #(
    parameter int                               SPRITE_W   = 3,
    parameter int                               SPRITE_H   = 3,
    parameter logic [7:0]                       ORIGIN_X   = 8'd79,
    parameter logic [6:0]                       ORIGIN_Y   = 7'd60,
    parameter logic [2:0]                       FG_COLOUR  = 3'b111,
    parameter logic [2:0]                       BG_COLOUR  = 3'b000,
    parameter logic [SPRITE_W*SPRITE_H-1:0]     MASK_UP    = 9'b101_111_010,
    parameter logic [SPRITE_W*SPRITE_H-1:0]     MASK_DOWN  = 9'b010_111_101,
    parameter logic [SPRITE_W*SPRITE_H-1:0]     MASK_LEFT  = 9'b110_111_110,
    parameter logic [SPRITE_W*SPRITE_H-1:0]     MASK_RIGHT = 9'b011_111_011
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] key_press,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       writeEn,
    output logic [1:0] direction,
    output logic       busy,
    output logic       done
);

    localparam int N  = SPRITE_W * SPRITE_H;
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] P_LAST   = PW'(N - 1);
    localparam logic [7:0]    COL_LAST = 8'(SPRITE_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ERASE,
        S_DRAW,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] p_q, p_d;
    logic [7:0]    col_q, col_d;
    logic [6:0]    row_q, row_d;
    logic [1:0]    pending_dir_q, pending_dir_d;
    logic [1:0]    direction_q, direction_d;
    logic          drawn_valid_q, drawn_valid_d;

    logic          key_valid;
    logic [1:0]    key_dir;

    // Mask table indexed by heading code (00 up, 01 down, 10 left, 11 right).
    logic [N-1:0]  mask_table [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
        if (gi == 0) begin : g_up
            assign mask_table[gi] = MASK_UP;
        end else if (gi == 1) begin : g_down
            assign mask_table[gi] = MASK_DOWN;
        end else if (gi == 2) begin : g_left
            assign mask_table[gi] = MASK_LEFT;
        end else begin : g_right
            assign mask_table[gi] = MASK_RIGHT;
        end
    end

    always_comb begin
        key_valid = 1'b1;
        key_dir   = 2'b00;
        case (key_press)
            4'b0100: key_dir = 2'b00;
            4'b0011: key_dir = 2'b01;
            4'b0001: key_dir = 2'b10;
            4'b0010: key_dir = 2'b11;
            default: key_valid = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q       <= S_IDLE;
            p_q           <= '0;
            col_q         <= '0;
            row_q         <= '0;
            pending_dir_q <= 2'b00;
            direction_q   <= 2'b00;
            drawn_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            p_q           <= p_d;
            col_q         <= col_d;
            row_q         <= row_d;
            pending_dir_q <= pending_dir_d;
            direction_q   <= direction_d;
            drawn_valid_q <= drawn_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        p_d           = p_q;
        col_d         = col_q;
        row_d         = row_q;
        pending_dir_d = pending_dir_q;
        direction_d   = direction_q;
        drawn_valid_d = drawn_valid_q;
        case (state_q)
            S_IDLE: begin
                if (key_valid && (!drawn_valid_q || key_dir != direction_q)) begin
                    pending_dir_d = key_dir;
                    p_d           = '0;
                    col_d         = '0;
                    row_d         = '0;
                    state_d       = drawn_valid_q ? S_ERASE : S_DRAW;
                end
            end
            S_ERASE, S_DRAW: begin
                if (p_q == P_LAST) begin
                    p_d     = '0;
                    col_d   = '0;
                    row_d   = '0;
                    state_d = (state_q == S_ERASE) ? S_DRAW : S_DONE;
                end else begin
                    // Column/row track p so no divider is needed for x/y.
                    p_d = p_q + PW'(1);
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        row_d = row_q + 7'd1;
                    end else begin
                        col_d = col_q + 8'd1;
                    end
                end
            end
            S_DONE: begin
                direction_d   = pending_dir_q;
                drawn_valid_d = 1'b1;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x       = 8'd0;
        y       = 7'd0;
        colour  = 3'b000;
        writeEn = 1'b0;
        case (state_q)
            S_ERASE: begin
                x       = ORIGIN_X + col_q;
                y       = ORIGIN_Y + row_q;
                colour  = BG_COLOUR;
                writeEn = 1'b1;
            end
            S_DRAW: begin
                x       = ORIGIN_X + col_q;
                y       = ORIGIN_Y + row_q;
                colour  = FG_COLOUR;
                writeEn = mask_table[pending_dir_q][p_q];
            end
            default: ;
        endcase
    end

    assign direction = direction_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ship_sprite_engine.sv
// Bench for ship_sprite_engine: a frame-level queue model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_ship_sprite_engine;

    localparam int         W     = 3;
    localparam int         N     = 9;
    localparam logic [8:0] M_UP  = 9'b101_111_010;
    localparam logic [8:0] M_DN  = 9'b010_111_101;
    localparam logic [8:0] M_LF  = 9'b110_111_110;
    localparam logic [8:0] M_RT  = 9'b011_111_011;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] key_press = 4'b0000;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       writeEn;
    logic [1:0] direction;
    logic       busy;
    logic       done;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #10 clk = ~clk;

    ship_sprite_engine dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .key_press (key_press),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .writeEn   (writeEn),
        .direction (direction),
        .busy      (busy),
        .done      (done)
    );

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       we;
        logic [1:0] dir;
        logic       busy;
        logic       done;
    } rec_t;

    function automatic rec_t idle_rec(input logic [1:0] d);
        rec_t r;
        r = '0;
        r.dir = d;
        return r;
    endfunction

    function automatic rec_t pix_rec(input int p, input logic [2:0] c, input logic we, input logic [1:0] d);
        rec_t r;
        r.x    = 8'((79 + p % W) % 256);
        r.y    = 7'((60 + p / W) % 128);
        r.c    = c;
        r.we   = we;
        r.dir  = d;
        r.busy = 1'b1;
        r.done = 1'b0;
        return r;
    endfunction

    function automatic bit decode(input logic [3:0] k, output logic [1:0] d);
        d = 2'b00;
        case (k)
            4'b0100: d = 2'b00;
            4'b0011: d = 2'b01;
            4'b0001: d = 2'b10;
            4'b0010: d = 2'b11;
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    function automatic logic [8:0] mask_of(input logic [1:0] d);
        case (d)
            2'b00:   return M_UP;
            2'b01:   return M_DN;
            2'b10:   return M_LF;
            default: return M_RT;
        endcase
    endfunction

    // Model: each accepted command enqueues its whole frame of expected outputs.
    rec_t       cur = '0;
    rec_t       q[$];
    logic [1:0] mdir = 2'b00;
    bit         mdrawn = 1'b0;

    always @(negedge clk) begin
        rec_t       act;
        rec_t       dn;
        logic [1:0] kd;
        logic [8:0] m;
        bit         kv;
        act = {x, y, colour, writeEn, direction, busy, done};
        if (chk_en) begin
            total++;
            if (act !== cur) begin
                bad++;
                $display("FAIL model_cycle t=%0t: got x=%0d y=%0d c=%0d we=%0b dir=%0d busy=%0b done=%0b, expected x=%0d y=%0d c=%0d we=%0b dir=%0d busy=%0b done=%0b",
                         $time, act.x, act.y, act.c, act.we, act.dir, act.busy, act.done,
                         cur.x, cur.y, cur.c, cur.we, cur.dir, cur.busy, cur.done);
            end
        end
        kv = decode(key_press, kd);
        if (reset) begin
            q.delete();
            mdir   = 2'b00;
            mdrawn = 1'b0;
            cur    = idle_rec(2'b00);
        end else if (!cur.busy && kv && (!mdrawn || kd != mdir)) begin
            m = mask_of(kd);
            if (mdrawn)
                for (int p = 0; p < N; p++) q.push_back(pix_rec(p, 3'b000, 1'b1, mdir));
            for (int p = 0; p < N; p++) q.push_back(pix_rec(p, 3'b111, m[p], mdir));
            dn = idle_rec(mdir);
            dn.busy = 1'b1;
            dn.done = 1'b1;
            q.push_back(dn);
            mdir   = kd;
            mdrawn = 1'b1;
            cur    = q.pop_front();
        end else if (q.size() > 0) begin
            cur = q.pop_front();
        end else begin
            cur = idle_rec(mdir);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input int chg_at, input logic [3:0] chg_key,
                             output int nbusy, output int nerase, output int ndraw,
                             output logic [8:0] we_bits, output int ndone, output int mid_chg,
                             output logic [7:0] lx, output logic [6:0] ly, output logic [1:0] dir_end);
        logic [1:0] d0;
        nbusy = 0; nerase = 0; ndraw = 0; we_bits = '0; ndone = 0; mid_chg = 0; lx = '0; ly = '0;
        d0 = direction;
        @(posedge clk); #1;
        while (busy === 1'b1 && nbusy < 200) begin
            nbusy++;
            if (direction !== d0) mid_chg++;
            if (done) ndone++;
            else if (colour == 3'b000 && writeEn) nerase++;
            else if (colour == 3'b111) begin
                if (ndraw < N) we_bits[ndraw] = writeEn;
                if (ndraw == chg_at) key_press = chg_key;
                lx = x;
                ly = y;
                ndraw++;
            end
            @(posedge clk); #1;
        end
        dir_end = direction;
    endtask

    initial begin
        int nb, ne, nd, ndn, mc, wcnt, bcnt;
        logic [8:0] wb;
        logic [7:0] lx;
        logic [6:0] ly;
        logic [1:0] de;
        logic [3:0] ign [4];

        reset = 1'b1;
        key_press = 4'b0000;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_colour", int'(colour), 0);
        check("rst_we", int'(writeEn), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dir", int'(direction), 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        key_press = 4'b0100;
        run_frame(-1, 4'b0000, nb, ne, nd, wb, ndn, mc, lx, ly, de);
        $display("frame up-first: busy=%0d erase=%0d draw=%0d we=%b dir=%0d", nb, ne, nd, wb, de);
        check("f1_busy", nb, 10);
        check("f1_erase", ne, 0);
        check("f1_draw", nd, 9);
        check("f1_we", int'(wb), int'(9'b101111010));
        check("f1_done", ndn, 1);
        check("f1_lastx", int'(lx), 81);
        check("f1_lasty", int'(ly), 62);
        check("f1_dir", int'(de), 0);

        key_press = 4'b0010;
        run_frame(-1, 4'b0000, nb, ne, nd, wb, ndn, mc, lx, ly, de);
        $display("frame right: busy=%0d erase=%0d draw=%0d we=%b dir=%0d", nb, ne, nd, wb, de);
        check("f2_busy", nb, 19);
        check("f2_erase", ne, 9);
        check("f2_we", int'(wb), int'(9'b011111011));
        check("f2_midchg", mc, 0);
        check("f2_dir", int'(de), 3);

        ign[0] = 4'b0010; ign[1] = 4'b0000; ign[2] = 4'b0101; ign[3] = 4'b1111;
        wcnt = 0;
        bcnt = 0;
        for (int i = 0; i < 4; i++) begin
            key_press = ign[i];
            repeat (13) begin
                @(posedge clk); #1;
                if (writeEn) wcnt++;
                if (busy) bcnt++;
            end
        end
        $display("ignored codes: we_cycles=%0d busy_cycles=%0d dir=%0d", wcnt, bcnt, direction);
        check("ign_we", wcnt, 0);
        check("ign_busy", bcnt, 0);
        check("ign_dir", int'(direction), 3);

        key_press = 4'b0100;
        run_frame(3, 4'b0011, nb, ne, nd, wb, ndn, mc, lx, ly, de);
        $display("frame up, key changed mid-draw: busy=%0d erase=%0d we=%b dir=%0d", nb, ne, wb, de);
        check("f3_busy", nb, 19);
        check("f3_we", int'(wb), int'(9'b101111010));
        check("f3_midchg", mc, 0);
        check("f3_dir", int'(de), 0);
        run_frame(-1, 4'b0000, nb, ne, nd, wb, ndn, mc, lx, ly, de);
        $display("frame down follow-on: busy=%0d erase=%0d we=%b dir=%0d", nb, ne, wb, de);
        check("f4_busy", nb, 19);
        check("f4_erase", ne, 9);
        check("f4_we", int'(wb), int'(9'b010111101));
        check("f4_dir", int'(de), 1);

        key_press = 4'b0001;
        @(posedge clk); #1;
        check("f5_erase_start", int'(busy), 1);
        repeat (4) @(posedge clk);
        #1;
        check("f5_p4_x", int'(x), 80);
        check("f5_p4_y", int'(y), 61);
        check("f5_p4_we", int'(writeEn), 1);
        reset = 1'b1;
        @(posedge clk); #1;
        $display("reset mid-erase: we=%0b busy=%0b dir=%0d", writeEn, busy, direction);
        check("abort_we", int'(writeEn), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_dir", int'(direction), 0);
        reset = 1'b0;
        key_press = 4'b0011;
        run_frame(-1, 4'b0000, nb, ne, nd, wb, ndn, mc, lx, ly, de);
        $display("frame down after reset: busy=%0d erase=%0d we=%b dir=%0d", nb, ne, wb, de);
        check("f6_busy", nb, 10);
        check("f6_erase", ne, 0);
        check("f6_we", int'(wb), int'(9'b010111101));
        check("f6_dir", int'(de), 1);

        repeat (3) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
